// File: rtl/music_score_player.sv
// Score RAM plus playback sequencer: stores fixed-size song slots of (key, duration)
// entries and plays one song, timing each note in beats from an external strobe.
module music_score_player #(
    parameter int KEY_WIDTH  = 4,
    parameter int TIME_WIDTH = 4,
    parameter int SONG_BITS  = 1,
    parameter int SLOT_BITS  = 5
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_writeEnable,
    input  logic [SONG_BITS+SLOT_BITS-1:0] i_writeAddress,
    input  logic [KEY_WIDTH-1:0]           i_keyIn,
    input  logic [TIME_WIDTH-1:0]          i_timeIn,
    input  logic [SONG_BITS-1:0]           i_songSelect,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_pause,
    input  logic                           i_loop,
    input  logic                           i_beatTick,
    output logic [KEY_WIDTH-1:0]           o_keyOut,
    output logic                           o_playing,
    output logic                           o_noteStart,
    output logic                           o_done,
    output logic [SLOT_BITS-1:0]           o_noteIndex
);

    localparam int ADDR_W  = SONG_BITS + SLOT_BITS;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRY_W = KEY_WIDTH + TIME_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [ENTRY_W-1:0]    r_rdData;
    logic [SONG_BITS-1:0]  r_song;
    logic [SLOT_BITS-1:0]  r_offset;
    logic [SLOT_BITS-1:0]  r_noteIndex;
    logic [KEY_WIDTH-1:0]  r_key;
    logic [TIME_WIDTH-1:0] r_remaining;
    logic                  r_noteStart;
    logic                  r_done;

    logic [KEY_WIDTH-1:0]  w_entryKey;
    logic [TIME_WIDTH-1:0] w_entryTime;
    logic                  w_isTerm;
    logic                  w_isSkip;
    logic                  w_lastOffset;
    logic                  w_beat;
    logic                  w_noteEnd;
    logic                  w_songEnd;
    logic                  w_emptySong;
    logic                  w_wrap;
    logic                  w_finish;

    // Read-first RAM: the registered read sees the old word on a same-cycle write.
    always_ff @(posedge i_clk) begin
        if (i_writeEnable) begin
            r_mem[i_writeAddress] <= {i_keyIn, i_timeIn};
        end
        r_rdData <= r_mem[{r_song, r_offset}];
    end

    assign w_entryKey   = r_rdData[ENTRY_W-1:TIME_WIDTH];
    assign w_entryTime  = r_rdData[TIME_WIDTH-1:0];
    assign w_isTerm     = (w_entryKey == '0) && (w_entryTime == '0);
    assign w_isSkip     = (w_entryKey != '0) && (w_entryTime == '0);
    assign w_lastOffset = (r_offset == '1);
    assign w_beat       = (r_state == PLAY) && i_beatTick && !i_pause;
    assign w_noteEnd    = w_beat && (r_remaining == TIME_WIDTH'(1));

    // A skip entry in the last slot position ends the song just like a terminator.
    assign w_songEnd    = ((r_state == LOAD) && (w_isTerm || (w_isSkip && w_lastOffset)))
                          || (w_noteEnd && w_lastOffset);
    assign w_emptySong  = (r_state == LOAD) && w_isTerm && (r_offset == '0);
    assign w_wrap       = w_songEnd && i_loop && !w_emptySong;
    assign w_finish     = w_songEnd && !w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (i_stop) begin
            w_nextState = IDLE;
        end else if (i_start) begin
            w_nextState = FETCH;
        end else begin
            unique case (r_state)
                IDLE:  w_nextState = IDLE;
                FETCH: w_nextState = LOAD;
                LOAD: begin
                    if (w_finish) begin
                        w_nextState = IDLE;
                    end else if (w_wrap || w_isSkip) begin
                        w_nextState = FETCH;
                    end else begin
                        w_nextState = PLAY;
                    end
                end
                PLAY: begin
                    if (w_noteEnd) begin
                        w_nextState = w_finish ? IDLE : FETCH;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        o_playing   = (r_state != IDLE);
        o_keyOut    = ((r_state == PLAY) && i_pause) ? '0 : r_key;
        o_noteStart = r_noteStart;
        o_done      = r_done;
        o_noteIndex = r_noteIndex;
    end

    // The key register holds across FETCH/LOAD so consecutive notes play without a gap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_song      <= '0;
            r_offset    <= '0;
            r_noteIndex <= '0;
            r_key       <= '0;
            r_remaining <= '0;
            r_noteStart <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_noteStart <= 1'b0;
            r_done      <= 1'b0;
            if (i_stop) begin
                r_key       <= '0;
                r_offset    <= '0;
                r_remaining <= '0;
                r_noteIndex <= '0;
            end else if (i_start) begin
                r_song   <= i_songSelect;
                r_offset <= '0;
            end else begin
                unique case (r_state)
                    LOAD: begin
                        if (w_finish) begin
                            r_key  <= '0;
                            r_done <= 1'b1;
                        end else if (w_wrap) begin
                            r_offset <= '0;
                        end else if (w_isSkip) begin
                            r_offset <= r_offset + SLOT_BITS'(1);
                        end else begin
                            r_key       <= w_entryKey;
                            r_remaining <= w_entryTime;
                            r_noteIndex <= r_offset;
                            r_noteStart <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (w_beat) begin
                            r_remaining <= r_remaining - TIME_WIDTH'(1);
                            if (w_noteEnd) begin
                                if (w_finish) begin
                                    r_key  <= '0;
                                    r_done <= 1'b1;
                                end else if (w_wrap) begin
                                    r_offset <= '0;
                                end else begin
                                    r_offset <= r_offset + SLOT_BITS'(1);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_score_player.sv
// Directed bench for music_score_player: stimulus pushes expected NoteStart/Done
// events into a queue and a negedge monitor pops and compares them as they occur.
module tb_music_score_player;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_writeEnable = 1'b0;
    logic [5:0] i_writeAddress = '0;
    logic [3:0] i_keyIn = '0;
    logic [3:0] i_timeIn = '0;
    logic [0:0] i_songSelect = '0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_loop = 1'b0;
    logic       i_beatTick = 1'b0;
    logic [3:0] o_keyOut;
    logic       o_playing;
    logic       o_noteStart;
    logic       o_done;
    logic [4:0] o_noteIndex;

    music_score_player #(
        .KEY_WIDTH(4), .TIME_WIDTH(4), .SONG_BITS(1), .SLOT_BITS(5)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_writeEnable(i_writeEnable),
        .i_writeAddress(i_writeAddress), .i_keyIn(i_keyIn), .i_timeIn(i_timeIn),
        .i_songSelect(i_songSelect), .i_start(i_start), .i_stop(i_stop),
        .i_pause(i_pause), .i_loop(i_loop), .i_beatTick(i_beatTick),
        .o_keyOut(o_keyOut), .o_playing(o_playing), .o_noteStart(o_noteStart),
        .o_done(o_done), .o_noteIndex(o_noteIndex)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int kind;
        int key;
        int idx;
        int at;
    } ev_t;

    ev_t expQ[$];
    ev_t monEv;
    int  checks = 0;
    int  failures = 0;
    int  actKind, actKey, actF2;

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Done events carry Playing in the index field, expected 0 with KeyOut 0.
    always @(negedge clk) begin
        if (o_noteStart || o_done) begin
            actKind = o_done ? 1 : 0;
            actKey  = int'(o_keyOut);
            actF2   = o_done ? int'(o_playing) : int'(o_noteIndex);
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpectedEvent: got kind=%0d key=%0d idx=%0d at cycle %0d, queue empty",
                         actKind, actKey, actF2, cyc);
            end else begin
                monEv = expQ.pop_front();
                if (actKind != monEv.kind || actKey != monEv.key ||
                    actF2 != monEv.idx || cyc != monEv.at) begin
                    failures++;
                    $display("[TB] FAIL event: got kind=%0d key=%0d idx=%0d cycle=%0d expected kind=%0d key=%0d idx=%0d cycle=%0d",
                             actKind, actKey, actF2, cyc, monEv.kind, monEv.key, monEv.idx, monEv.at);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic writeEntry(int song, int off, int key, int tm);
        i_writeEnable  = 1'b1;
        i_writeAddress = 6'(song * 32 + off);
        i_keyIn        = 4'(key);
        i_timeIn       = 4'(tm);
        step();
        i_writeEnable  = 1'b0;
    endtask

    task automatic startSong(int song, output int c);
        i_songSelect = 1'(song);
        i_start      = 1'b1;
        c            = cyc;
        step();
        i_start      = 1'b0;
    endtask

    task automatic beat(output int t);
        i_beatTick = 1'b1;
        t          = cyc;
        step();
        i_beatTick = 1'b0;
    endtask

    task automatic expectNote(int key, int idx, int at);
        ev_t e;
        e.kind = 0; e.key = key; e.idx = idx; e.at = at;
        expQ.push_back(e);
    endtask

    task automatic expectDone(int at);
        ev_t e;
        e.kind = 1; e.key = 0; e.idx = 0; e.at = at;
        expQ.push_back(e);
    endtask

    // Plays the stored song 0 (1,2),(2,1),(0,0) with a tick every 4 cycles.
    task automatic playSongZero(string tag);
        int c, t;
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(3);
        beat(t);
        idle(3);
        beat(t);
        expectNote(2, 1, t + 3);
        checkOutput({tag, "_hold1"}, int'(o_keyOut), 1);
        idle(1);
        checkOutput({tag, "_hold2"}, int'(o_keyOut), 1);
        idle(2);
        beat(t);
        expectDone(t + 3);
        idle(5);
        checkOutput({tag, "_keyAfter"}, int'(o_keyOut), 0);
        checkOutput({tag, "_playingAfter"}, int'(o_playing), 0);
    endtask

    task automatic applyStimulus();
        int c, t;

        idle(3);
        checkOutput("rst_key", int'(o_keyOut), 0);
        checkOutput("rst_playing", int'(o_playing), 0);
        checkOutput("rst_noteStart", int'(o_noteStart), 0);
        checkOutput("rst_done", int'(o_done), 0);
        checkOutput("rst_noteIndex", int'(o_noteIndex), 0);
        i_reset = 1'b0;

        writeEntry(0, 0, 1, 2);
        writeEntry(0, 1, 2, 1);
        writeEntry(0, 2, 0, 0);
        writeEntry(1, 0, 0, 3);
        writeEntry(1, 1, 7, 0);
        writeEntry(1, 2, 5, 1);
        writeEntry(1, 3, 0, 0);
        idle(2);

        playSongZero("t1");

        // Looping: the terminator sends playback back to offset 0.
        i_loop = 1'b1;
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(3);
        beat(t);
        idle(3);
        beat(t);
        expectNote(2, 1, t + 3);
        idle(3);
        beat(t);
        expectNote(1, 0, t + 5);
        idle(5);
        i_loop = 1'b0;
        beat(t);
        idle(3);
        beat(t);
        expectNote(2, 1, t + 3);
        idle(3);
        beat(t);
        expectDone(t + 3);
        idle(5);
        checkOutput("t2_playing", int'(o_playing), 0);

        // Rest, skipped entry, then key 5.
        startSong(1, c);
        expectNote(0, 0, c + 3);
        idle(2);
        checkOutput("t3_restKey", int'(o_keyOut), 0);
        checkOutput("t3_restPlaying", int'(o_playing), 1);
        idle(1);
        beat(t);
        idle(3);
        beat(t);
        idle(3);
        beat(t);
        expectNote(5, 2, t + 5);
        idle(5);
        checkOutput("t3_key5", int'(o_keyOut), 5);
        beat(t);
        expectDone(t + 3);
        idle(5);

        // Pause freezes the count and mutes the key.
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(3);
        beat(t);
        i_pause = 1'b1;
        idle(1);
        checkOutput("t4_pausedKey", int'(o_keyOut), 0);
        repeat (5) begin
            beat(t);
            idle(1);
        end
        checkOutput("t4_pausedKey2", int'(o_keyOut), 0);
        checkOutput("t4_pausedPlaying", int'(o_playing), 1);
        i_pause = 1'b0;
        idle(1);
        checkOutput("t4_restored", int'(o_keyOut), 1);
        beat(t);
        expectNote(2, 1, t + 3);
        idle(3);
        beat(t);
        expectDone(t + 3);
        idle(5);

        // Stop outranks Start; then a restart onto song 1.
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(4);
        i_stop = 1'b1;
        i_start = 1'b1;
        i_songSelect = 1'b1;
        step();
        i_stop = 1'b0;
        i_start = 1'b0;
        checkOutput("t5_stopKey", int'(o_keyOut), 0);
        checkOutput("t5_stopPlaying", int'(o_playing), 0);
        idle(6);
        checkOutput("t5_stillIdle", int'(o_playing), 0);
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(3);
        startSong(1, c);
        expectNote(0, 0, c + 3);
        checkOutput("t5_restartHold", int'(o_keyOut), 1);
        idle(2);
        checkOutput("t5_restartKey", int'(o_keyOut), 0);
        checkOutput("t5_restartPlaying", int'(o_playing), 1);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        idle(2);

        // Reset during the second note, then replay from intact RAM.
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(3);
        beat(t);
        idle(3);
        beat(t);
        expectNote(2, 1, t + 3);
        idle(4);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        checkOutput("t6_rstKey", int'(o_keyOut), 0);
        checkOutput("t6_rstPlaying", int'(o_playing), 0);
        checkOutput("t6_rstIndex", int'(o_noteIndex), 0);
        checkOutput("t6_rstNoteStart", int'(o_noteStart), 0);
        checkOutput("t6_rstDone", int'(o_done), 0);
        idle(2);
        playSongZero("t6replay");

        // Empty song ends at once even with Loop high.
        writeEntry(1, 0, 0, 0);
        i_loop = 1'b1;
        startSong(1, c);
        expectDone(c + 3);
        idle(2);
        checkOutput("t6_emptyPlaying", int'(o_playing), 0);
        checkOutput("t6_emptyKey", int'(o_keyOut), 0);
        i_loop = 1'b0;
        idle(3);

        // Full slot: 32 one-beat notes, Done after entry 31, no wrap.
        for (int i = 0; i < 32; i++) begin
            writeEntry(0, i, (i % 15) + 1, 1);
        end
        startSong(0, c);
        expectNote(1, 0, c + 3);
        idle(2);
        for (int i = 0; i < 32; i++) begin
            beat(t);
            if (i < 31) begin
                expectNote(((i + 1) % 15) + 1, i + 1, t + 3);
                idle(2);
            end else begin
                expectDone(t + 1);
            end
        end
        idle(8);
        checkOutput("t6_fullPlaying", int'(o_playing), 0);
        checkOutput("t6_fullKey", int'(o_keyOut), 0);

        checkOutput("queueEmpty", expQ.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
